// File: rtl/cpu65_dma_ctrl.sv
// Bus-mastering block-copy DMA for the cpu65 bus: halts the core via RDY, takes the bus via AEC.
// Optional fill mode (constant byte to dst, no reads) is enabled by defining DMA_FILL_EN.
module cpu65_dma_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [15:0] cfg_wdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        cpu_rwn,
  input  logic        cpu_mln,
  output logic        rdy_o,
  output logic        aec_o,
  output logic [15:0] bus_a_o,
  output logic        bus_a_oe,
  output logic        bus_rwn_o,
  output logic [7:0]  bus_d_o,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_d_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_GRANT, S_RD, S_WR, S_RELEASE, S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_len;
  logic        r_busy;
  logic        r_done;
  logic        r_rdy;
  logic        r_aec;
  logic [15:0] r_a;
  logic        r_a_oe;
  logic        r_rwn;
  logic [7:0]  r_d;
  logic        r_d_oe;
  logic        w_fill;
  logic [7:0]  w_fill_byte;

`ifdef DMA_FILL_EN
  logic        r_fill_mode;
  logic [7:0]  r_fill;
  assign w_fill      = r_fill_mode;
  assign w_fill_byte = r_fill;
`else
  assign w_fill      = 1'b0;
  assign w_fill_byte = 8'h00;
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign rdy_o     = r_rdy;
  assign aec_o     = r_aec;
  assign bus_a_o   = r_a;
  assign bus_a_oe  = r_a_oe;
  assign bus_rwn_o = r_rwn;
  assign bus_d_o   = r_d;
  assign bus_d_oe  = r_d_oe;

  // All outputs are registered and set on the transition into the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_src   <= 16'h0000;
      r_dst   <= 16'h0000;
      r_len   <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdy   <= 1'b1;
      r_aec   <= 1'b1;
      r_a     <= 16'h0000;
      r_a_oe  <= 1'b0;
      r_rwn   <= 1'b1;
      r_d     <= 8'h00;
      r_d_oe  <= 1'b0;
`ifdef DMA_FILL_EN
      r_fill_mode <= 1'b0;
      r_fill      <= 8'h00;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_we) begin
            case (cfg_sel)
              2'd0: r_src <= cfg_wdata;
              2'd1: r_dst <= cfg_wdata;
`ifdef DMA_FILL_EN
              2'd2: begin
                r_len       <= {1'b0, cfg_wdata[14:0]};
                r_fill_mode <= cfg_wdata[15];
              end
              2'd3: r_fill <= cfg_wdata[7:0];
`else
              2'd2: r_len <= cfg_wdata;
`endif
              default: ;
            endcase
          end
          // The zero-length test sees the pre-write length when cfg_we and start coincide.
          if (start) begin
            if (r_len != 16'h0000) begin
              r_state <= S_HALT;
              r_busy  <= 1'b1;
              r_rdy   <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (cpu_rwn && cpu_mln) begin
            r_state <= S_GRANT;
            r_aec   <= 1'b0;
          end
        end
        S_GRANT: begin
          r_a_oe <= 1'b1;
          if (w_fill) begin
            r_state <= S_WR;
            r_a     <= r_dst;
            r_rwn   <= 1'b0;
            r_d     <= w_fill_byte;
            r_d_oe  <= 1'b1;
          end else begin
            r_state <= S_RD;
            r_a     <= r_src;
            r_rwn   <= 1'b1;
          end
        end
        S_RD: begin
          r_state <= S_WR;
          r_a     <= r_dst;
          r_rwn   <= 1'b0;
          r_d     <= bus_d_i;
          r_d_oe  <= 1'b1;
        end
        S_WR: begin
          if (!w_fill) r_src <= r_src + 16'd1;
          r_dst <= r_dst + 16'd1;
          r_len <= r_len - 16'd1;
          if (r_len == 16'd1) begin
            r_state <= S_RELEASE;
            r_a_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
            r_rwn   <= 1'b1;
          end else if (w_fill) begin
            r_a <= r_dst + 16'd1;
          end else begin
            r_state <= S_RD;
            r_a     <= r_src + 16'd1;
            r_rwn   <= 1'b1;
            r_d_oe  <= 1'b0;
          end
        end
        S_RELEASE: begin
          r_state <= S_DONE;
          r_aec   <= 1'b1;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu65_dma_ctrl.sv
// Scoreboarded bench for cpu65_dma_ctrl: a 64 KiB memory model serves the bus and every DMA
// read/write cycle is popped against expected addresses/data queued when a transfer is set up.
module tb_cpu65_dma_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [15:0] cfg_wdata = 16'h0000;
  logic        start = 1'b0;
  logic        busy, done;
  logic        cpu_rwn = 1'b1;
  logic        cpu_mln = 1'b1;
  logic        rdy_o, aec_o;
  logic [15:0] bus_a_o;
  logic        bus_a_oe, bus_rwn_o;
  logic [7:0]  bus_d_o;
  logic        bus_d_oe;
  logic [7:0]  bus_d_i;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  wr_t         wr_q[$];
  int          checks = 0;
  int          errors = 0;

  cpu65_dma_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy), .done(done), .cpu_rwn(cpu_rwn), .cpu_mln(cpu_mln),
    .rdy_o(rdy_o), .aec_o(aec_o), .bus_a_o(bus_a_o), .bus_a_oe(bus_a_oe),
    .bus_rwn_o(bus_rwn_o), .bus_d_o(bus_d_o), .bus_d_oe(bus_d_oe), .bus_d_i(bus_d_i)
  );

  always #5 clk_i = ~clk_i;

  assign bus_d_i = mem[bus_a_o];

  // A system reset aborts the bus cycle in flight, so no write commits under reset.
  always @(posedge clk_i)
    if (!rst_i && bus_a_oe && !bus_rwn_o && bus_d_oe) mem[bus_a_o] <= bus_d_o;

  always @(negedge clk_i) begin
    if (bus_a_oe === 1'b1) begin
      checks++;
      if (aec_o !== 1'b0) begin
        errors++;
        $display("FAIL aec_encloses: aec_o=%b while bus_a_oe=1, want 0", aec_o);
      end
      checks++;
      if (bus_rwn_o) begin
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: addr=%h, no read expected", bus_a_o);
        end else begin
          logic [15:0] ea;
          ea = rd_q.pop_front();
          if (bus_a_o !== ea || bus_d_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_cycle: addr=%h d_oe=%b, want addr=%h d_oe=0", bus_a_o, bus_d_oe, ea);
          end
        end
      end else begin
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h, no write expected", bus_a_o, bus_d_o);
        end else begin
          wr_t ew;
          ew = wr_q.pop_front();
          if (bus_a_o !== ew.a || bus_d_o !== ew.d || bus_d_oe !== 1'b1) begin
            errors++;
            $display("FAIL write_cycle: addr=%h data=%h d_oe=%b, want addr=%h data=%h d_oe=1",
                     bus_a_o, bus_d_o, bus_d_oe, ew.a, ew.d);
          end
        end
      end
    end
  end

  task automatic cfg(input logic [1:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    @(negedge clk_i);
    cfg_we = 1'b0;
  endtask

  task automatic expect_copy(input logic [15:0] src, input logic [15:0] dst, input int len);
    logic [15:0] s, d;
    s = src; d = dst;
    for (int i = 0; i < len; i++) begin
      rd_q.push_back(s);
      wr_q.push_back('{a: d, d: mem[s]});
      s = s + 16'd1; d = d + 16'd1;
    end
  endtask

  task automatic run_xfer(input string name, input int exp_cycles);
    int cyc;
    start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    cyc = 1;
    if (exp_cycles > 1) begin
      checks++;
      if (busy !== 1'b1 || rdy_o !== 1'b0 || aec_o !== 1'b1) begin
        errors++;
        $display("FAIL %s_start: busy=%b rdy=%b aec=%b, want 1 0 1", name, busy, rdy_o, aec_o);
      end
    end
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, want 1", name, done, cyc);
    end else if (cyc != exp_cycles) begin
      errors++;
      $display("FAIL %s_cycles: done at cycle %0d, want %0d", name, cyc, exp_cycles);
    end
    checks++;
    if (rdy_o !== 1'b1 || aec_o !== 1'b1 || busy !== 1'b0 || bus_a_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_state: rdy=%b aec=%b busy=%b a_oe=%b, want 1 1 0 0",
               name, rdy_o, aec_o, busy, bus_a_oe);
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d reads %0d writes outstanding, want 0 0",
               name, rd_q.size(), wr_q.size());
      rd_q.delete(); wr_q.delete();
    end
    @(negedge clk_i);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, want 0", name, done);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({rdy_o, aec_o, bus_a_oe, bus_d_oe, bus_rwn_o, busy, done} !== 7'b1100100) begin
      errors++;
      $display("FAIL reset_ctrl: {rdy,aec,a_oe,d_oe,rwn,busy,done}=%b, want 1100100",
               {rdy_o, aec_o, bus_a_oe, bus_d_oe, bus_rwn_o, busy, done});
    end
    checks++;
    if (bus_a_o !== 16'h0000 || bus_d_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: a=%h d=%h, want 0000 00", bus_a_o, bus_d_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_copy;
    cfg(2'd0, 16'h0200); cfg(2'd1, 16'h0300); cfg(2'd2, 16'd4);
    expect_copy(16'h0200, 16'h0300, 4);
    run_xfer("copy", 12);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0300 + i] !== mem[16'h0200 + i]) begin
        errors++;
        $display("FAIL copy_mem[%0d]: %h, want %h", i, mem[16'h0300 + i], mem[16'h0200 + i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    // src/dst are not rewritten: the next byte must come from 0x0204 and land at 0x0304.
    cfg(2'd2, 16'd1);
    expect_copy(16'h0204, 16'h0304, 1);
    run_xfer("b2b_one", 6);
    run_xfer("b2b_len_cleared", 1);
  endtask

  task automatic test_halt_deferral;
    int cyc;
    cfg(2'd0, 16'h0700); cfg(2'd1, 16'h0800); cfg(2'd2, 16'd2);
    expect_copy(16'h0700, 16'h0800, 2);
    cpu_rwn = 1'b0;
    start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    checks++;
    if (rdy_o !== 1'b0 || aec_o !== 1'b1) begin
      errors++;
      $display("FAIL defer_halt: rdy=%b aec=%b, want 0 1", rdy_o, aec_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin cpu_rwn = 1'b1; cpu_mln = 1'b0; end
      @(negedge clk_i);
      checks++;
      if (aec_o !== 1'b1) begin
        errors++;
        $display("FAIL defer_hold[%0d]: aec=%b, want 1", i, aec_o);
      end
    end
    cpu_mln = 1'b1;
    @(negedge clk_i);
    checks++;
    if (aec_o !== 1'b0) begin
      errors++;
      $display("FAIL defer_grant: aec=%b, want 0", aec_o);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != 6) begin
      errors++;
      $display("FAIL defer_done: done=%b after %0d cycles, want 1 after 6", done, cyc);
    end
    @(negedge clk_i);
  endtask

  task automatic test_wrap;
    logic [7:0] exp_b [4];
    logic [15:0] s;
    s = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      exp_b[i] = mem[s];
      s = s + 16'd1;
    end
    cfg(2'd0, 16'hFFFE); cfg(2'd1, 16'h1000); cfg(2'd2, 16'd4);
    expect_copy(16'hFFFE, 16'h1000, 4);
    run_xfer("wrap", 12);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h1000 + i] !== exp_b[i]) begin
        errors++;
        $display("FAIL wrap_mem[%0d]: %h, want %h", i, mem[16'h1000 + i], exp_b[i]);
      end
    end
  endtask

  task automatic test_len0;
    cfg(2'd2, 16'd0);
    run_xfer("len0", 1);
    cfg(2'd0, 16'h0900); cfg(2'd1, 16'h0A00);
    // cfg write and start together: start sees the old length of zero.
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_wdata = 16'd3;
    run_xfer("len0_simul_cfg", 1);
    cfg_we = 1'b0;
    expect_copy(16'h0900, 16'h0A00, 3);
    run_xfer("len3_after_simul", 10);
  endtask

  task automatic test_reset_midxfer;
    logic [7:0] orig2, orig3;
    int nwr, cyc;
    orig2 = mem[16'h0602]; orig3 = mem[16'h0603];
    cfg(2'd0, 16'h0500); cfg(2'd1, 16'h0600); cfg(2'd2, 16'd4);
    expect_copy(16'h0500, 16'h0600, 3);
    start = 1'b1;
    @(negedge clk_i);
    start = 1'b0;
    nwr = 0; cyc = 0;
    while (nwr < 3 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (bus_a_oe === 1'b1 && bus_rwn_o === 1'b0) nwr++;
    end
    checks++;
    if (nwr != 3) begin
      errors++;
      $display("FAIL midrst_third_wr: saw %0d writes, want 3", nwr);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({rdy_o, aec_o, bus_a_oe, bus_d_oe, bus_rwn_o, busy, done} !== 7'b1100100 ||
        bus_a_o !== 16'h0000 || bus_d_o !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs: ctrl=%b a=%h d=%h, want 1100100 0000 00",
               {rdy_o, aec_o, bus_a_oe, bus_d_oe, bus_rwn_o, busy, done}, bus_a_o, bus_d_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (mem[16'h0600] !== mem[16'h0500] || mem[16'h0601] !== mem[16'h0501] ||
        mem[16'h0602] !== orig2 || mem[16'h0603] !== orig3) begin
      errors++;
      $display("FAIL midrst_mem: %h %h %h %h, want %h %h %h %h", mem[16'h0600], mem[16'h0601],
               mem[16'h0602], mem[16'h0603], mem[16'h0500], mem[16'h0501], orig2, orig3);
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_pending: %0d reads %0d writes, want 0 0", rd_q.size(), wr_q.size());
      rd_q.delete(); wr_q.delete();
    end
  endtask

`ifdef DMA_FILL_EN
  task automatic test_fill;
    cfg(2'd3, 16'h00A5); cfg(2'd1, 16'h0400); cfg(2'd2, 16'h8003);
    for (int i = 0; i < 3; i++) wr_q.push_back('{a: 16'h0400 + 16'(i), d: 8'hA5});
    run_xfer("fill", 7);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h0400 + i] !== 8'hA5) begin
        errors++;
        $display("FAIL fill_mem[%0d]: %h, want a5", i, mem[16'h0400 + i]);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'((i * 37) ^ (i >> 8) ^ 8'h5A);
    @(negedge clk_i);
    test_reset;
    test_copy;
    test_back_to_back;
    test_halt_deferral;
    test_wrap;
    test_len0;
    test_reset_midxfer;
`ifdef DMA_FILL_EN
    test_fill;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
